// File: rtl/haar_stage_collector.sv
// haar_stage_collector: rebuilds serial parameter words into classifier records and stage thresholds
module haar_stage_collector #(
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int NUM_CLASSIFIERS_STAGE    = 9
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               en,
  input  logic                                               i_valid,
  input  logic [DATA_WIDTH_12-1:0]                           i_data,
  input  logic                                               i_end_single_classifier,
  input  logic                                               i_end_database,
  output logic                                               o_ready,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0]  o_classifier,
  output logic [11:0]                                        o_index_classifier,
  output logic                                               o_classifier_valid,
  input  logic                                               i_classifier_ready,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_12-1:0]       o_stage_threshold,
  output logic                                               o_stage_threshold_valid,
  output logic                                               o_error
);
  localparam int TW = NUM_STAGE_THRESHOLD > 1 ? $clog2(NUM_STAGE_THRESHOLD) : 1;
  localparam logic [4:0]  LAST_P = 5'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [11:0] LAST_C = 12'(NUM_CLASSIFIERS_STAGE - 1);
  localparam logic [11:0] LAST_T = 12'(NUM_STAGE_THRESHOLD - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, HOLD, THRESH, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] param_cnt;
  logic [11:0] thr_cnt;
  logic [DATA_WIDTH_12-1:0] rec [NUM_PARAM_PER_CLASSIFIER];
  logic [DATA_WIDTH_12-1:0] thr [NUM_STAGE_THRESHOLD];
  logic acc, frame_err;
  assign o_ready                 = state == COLLECT || state == THRESH;
  assign o_classifier_valid      = state == HOLD;
  assign o_stage_threshold_valid = state == DONE;
  assign acc                     = i_valid && o_ready;
  // flags only police framing; the counters alone decide where words go
  assign frame_err = acc && (state == COLLECT
    ? (i_end_single_classifier != (param_cnt == LAST_P)) || i_end_database
    : i_end_single_classifier || (i_end_database != (thr_cnt == LAST_T)));
  for (genvar k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) begin : g_rec
    assign o_classifier[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = rec[k];
  end
  for (genvar k = 0; k < NUM_STAGE_THRESHOLD; k++) begin : g_thr
    assign o_stage_threshold[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = thr[k];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = COLLECT;
      COLLECT: state_nx = acc && param_cnt == LAST_P ? HOLD : COLLECT;
      HOLD:    state_nx = !i_classifier_ready ? HOLD : o_index_classifier == LAST_C ? THRESH : COLLECT;
      THRESH:  state_nx = acc && thr_cnt == LAST_T ? DONE : THRESH;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      param_cnt          <= '0;
      thr_cnt            <= '0;
      o_index_classifier <= '0;
      o_error            <= 1'b0;
      for (int k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) rec[k] <= '0;
      for (int k = 0; k < NUM_STAGE_THRESHOLD; k++) thr[k] <= '0;
    end else if (!en) begin
      state              <= IDLE;
      param_cnt          <= '0;
      thr_cnt            <= '0;
      o_index_classifier <= '0;
      o_error            <= 1'b0;
      for (int k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) rec[k] <= '0;
      for (int k = 0; k < NUM_STAGE_THRESHOLD; k++) thr[k] <= '0;
    end else begin
      state   <= state_nx;
      o_error <= o_error | frame_err;
      if (acc && state == COLLECT) begin
        rec[param_cnt] <= i_data;
        param_cnt      <= param_cnt + 5'd1;
      end
      if (state == HOLD && i_classifier_ready) begin
        param_cnt          <= '0;
        o_index_classifier <= o_index_classifier + 12'd1;
      end
      if (acc && state == THRESH) begin
        thr[thr_cnt[TW-1:0]] <= i_data;
        thr_cnt              <= thr_cnt + 12'd1;
      end
    end
  end
endmodule
